// File: rtl/uart_word_streamer.sv
// Unpacks 32-bit capture-RAM words into bytes (LSB first) for the UART byte transmitter.
// A frame of WORD_COUNT words is started and aborted from active-low pushbuttons.
module uart_word_streamer #(
    parameter int ADDR_W     = 12,
    parameter int WORD_COUNT = 768
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              STOP,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_EN,
    input  logic [31:0]       RD_DATA,
    output logic [7:0]        TX_DATA,
    output logic              TX_START,
    input  logic              TX_BUSY,
    output logic              ACTIVE,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        WAIT_HI,
        WAIT_LO,
        NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       word_q;
    logic              load_word;
    logic [7:0]        tx_data_d;
    logic              tx_start_d;
    logic              rd_en_d;
    logic              active_d;
    logic              done_d;

    // Pushbuttons are asynchronous: two flops each, plus one more on START for edge detection.
    logic [1:0] start_sync;
    logic       start_prev;
    logic [1:0] stop_sync;
    logic       start_edge;
    logic       stop_req;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            start_sync <= 2'b11;
            start_prev <= 1'b1;
            stop_sync  <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous stage's old value.
            start_sync <= {start_sync[0], START};
            start_prev <= start_sync[1];
            stop_sync  <= {stop_sync[0], STOP};
        end
    end

    assign start_edge = start_prev & ~start_sync[1];
    assign stop_req   = ~stop_sync[1];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        load_word  = 1'b0;
        tx_data_d  = TX_DATA;
        tx_start_d = 1'b0;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;

        if (stop_req) begin
            // Abort wins over everything, including a START edge in the same cycle.
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        addr_d  = '0;
                        rd_en_d = 1'b1;
                        state_d = READ;
                    end
                end
                READ: begin
                    state_d = LATCH;
                end
                LATCH: begin
                    load_word = 1'b1;
                    lane_d    = 2'd0;
                    state_d   = SEND;
                end
                SEND: begin
                    if (!TX_BUSY) begin
                        tx_data_d  = word_q[{lane_q, 3'b000} +: 8];
                        tx_start_d = 1'b1;
                        state_d    = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (TX_BUSY) begin
                        state_d = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (lane_q != 2'd3) begin
                        lane_d  = lane_q + 2'd1;
                        state_d = SEND;
                    end else if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        addr_d  = '0;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        rd_en_d = 1'b1;
                        state_d = READ;
                    end
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            endcase
        end

        active_d = (state_d != IDLE);
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            lane_q   <= 2'd0;
            TX_DATA  <= 8'h00;
            TX_START <= 1'b0;
            RD_EN    <= 1'b0;
            ACTIVE   <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lane_q   <= lane_d;
            TX_DATA  <= tx_data_d;
            TX_START <= tx_start_d;
            RD_EN    <= rd_en_d;
            ACTIVE   <= active_d;
            DONE     <= done_d;
        end
    end

    // NOTE: the word register has no reset; it is always loaded in LATCH before any byte is taken from it.
    always_ff @(posedge CLOCK_50) begin
        if (load_word) begin
            word_q <= RD_DATA;
        end
    end

    assign RD_ADDR = addr_q;

endmodule
